// File: rtl/fx2_issue_ctrl_if.sv
// Request / issue / writeback bundle shared by fx2_issue_ctrl and whatever drives it.
// The FX2 issue controller uses the slave modport; requesters and the writeback consumer use master.
interface fx2_issue_ctrl_if #(
    parameter int REG_W = 7
);
    // reqN_valid is the offer and gntN is its ready; an instruction transfers in a cycle where both
    // are high. A requester that is not granted keeps valid and its fields stable, or drops valid.
    logic             req0_valid;
    logic [6:0]       req0_instr_id;
    logic [REG_W-1:0] req0_ra;
    logic [REG_W-1:0] req0_rb;
    logic [REG_W-1:0] req0_rt;
    logic             req1_valid;
    logic [6:0]       req1_instr_id;
    logic [REG_W-1:0] req1_ra;
    logic [REG_W-1:0] req1_rb;
    logic [REG_W-1:0] req1_rt;
    logic             gnt0;
    logic             gnt1;
    logic             alu_sel;
    logic [6:0]       alu_instr_id;
    logic             flush;
    logic             wb_valid;
    logic [REG_W-1:0] wb_rt;
    logic [6:0]       wb_instr_id;
    logic             busy;
    logic             dbg_ptr;

    modport master (
        output req0_valid, req0_instr_id, req0_ra, req0_rb, req0_rt,
        output req1_valid, req1_instr_id, req1_ra, req1_rb, req1_rt,
        output flush,
        input  gnt0, gnt1, alu_sel, alu_instr_id,
        input  wb_valid, wb_rt, wb_instr_id, busy, dbg_ptr
    );

    modport slave (
        input  req0_valid, req0_instr_id, req0_ra, req0_rb, req0_rt,
        input  req1_valid, req1_instr_id, req1_ra, req1_rb, req1_rt,
        input  flush,
        output gnt0, gnt1, alu_sel, alu_instr_id,
        output wb_valid, wb_rt, wb_instr_id, busy, dbg_ptr
    );
endinterface

// File: rtl/fx2_issue_ctrl.sv
// Two-requester round-robin issue controller for the FX2 rotate/shift unit with a LATENCY-deep
// writeback tag pipe. Define FX2_HAZARD_EN to add the RAW interlock against in-flight destinations.
module fx2_issue_ctrl #(
    parameter int LATENCY = 4,
    parameter int REG_W   = 7
) (
    input logic             clk,
    input logic             rst_n,
    fx2_issue_ctrl_if.slave bus
);
    logic             r_vld [1:LATENCY];
    logic [REG_W-1:0] r_rt  [1:LATENCY];
    logic [6:0]       r_id  [1:LATENCY];
    logic             r_ptr;
    logic             r_alu_sel;

    logic             w_haz0;
    logic             w_haz1;
    logic             w_elig0;
    logic             w_elig1;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_any;
    logic             w_sel;
    logic             w_ptr_nxt;
    logic             w_busy;
    logic [REG_W-1:0] w_rt_in;
    logic [6:0]       w_id_in;

`ifdef FX2_HAZARD_EN
    // The last stage retires this cycle, so a reader of its rt may issue alongside the writeback.
    always_comb begin
        w_haz0 = 1'b0;
        w_haz1 = 1'b0;
        for (int k = 1; k < LATENCY; k++) begin
            if (r_vld[k] && ((bus.req0_ra == r_rt[k]) || (bus.req0_rb == r_rt[k]))) w_haz0 = 1'b1;
            if (r_vld[k] && ((bus.req1_ra == r_rt[k]) || (bus.req1_rb == r_rt[k]))) w_haz1 = 1'b1;
        end
    end
`else
    assign w_haz0 = 1'b0;
    assign w_haz1 = 1'b0;
    logic w_unused_addr;
    assign w_unused_addr = ^{bus.req0_ra, bus.req0_rb, bus.req1_ra, bus.req1_rb};
`endif

    always_comb begin
        w_elig0 = bus.req0_valid && !w_haz0;
        w_elig1 = bus.req1_valid && !w_haz1;
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        if (rst_n && !bus.flush) begin
            if (w_elig0 && w_elig1) begin
                w_gnt0 = !r_ptr;
                w_gnt1 = r_ptr;
            end else begin
                w_gnt0 = w_elig0;
                w_gnt1 = w_elig1;
            end
        end
        w_any     = w_gnt0 | w_gnt1;
        w_sel     = w_gnt1;
        w_ptr_nxt = w_any ? ~w_sel : r_ptr;
        w_rt_in   = w_gnt1 ? bus.req1_rt : (w_gnt0 ? bus.req0_rt : '0);
        w_id_in   = w_gnt1 ? bus.req1_instr_id : (w_gnt0 ? bus.req0_instr_id : 7'd0);
    end

    always_comb begin
        w_busy = 1'b0;
        for (int k = 1; k <= LATENCY; k++) begin
            if (r_vld[k]) w_busy = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 1; k <= LATENCY; k++) begin
                r_vld[k] <= 1'b0;
                r_rt[k]  <= '0;
                r_id[k]  <= '0;
            end
            r_ptr     <= 1'b0;
            r_alu_sel <= 1'b0;
        end else begin
            // Flush blocks the grant, so stage 1 only needs w_any; deeper stages are killed here.
            r_vld[1] <= w_any;
            r_rt[1]  <= w_rt_in;
            r_id[1]  <= w_id_in;
            for (int k = 2; k <= LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1] && !bus.flush;
                r_rt[k]  <= r_rt[k-1];
                r_id[k]  <= r_id[k-1];
            end
            r_ptr <= w_ptr_nxt;
            if (w_any) r_alu_sel <= w_sel;
        end
    end

    assign bus.gnt0         = w_gnt0;
    assign bus.gnt1         = w_gnt1;
    assign bus.alu_sel      = w_any ? w_sel : r_alu_sel;
    assign bus.alu_instr_id = w_id_in;
    assign bus.wb_valid     = r_vld[LATENCY];
    assign bus.wb_rt        = r_rt[LATENCY];
    assign bus.wb_instr_id  = r_id[LATENCY];
    assign bus.busy         = w_busy;
    assign bus.dbg_ptr      = r_ptr;
endmodule

// File: tb/tb_fx2_issue_ctrl.sv
// Bench for fx2_issue_ctrl: arbitration vector table, directed multi-cycle sequences,
// and a randomized run against a due-time reference model (LATENCY=4 plus a LATENCY=2 instance).
module tb_fx2_issue_ctrl;
    localparam int L  = 4;
    localparam int L2 = 2;

    localparam logic [6:0] ID_ROT   = 7'h58;
    localparam logic [6:0] ID_ROTH  = 7'h5c;
    localparam logic [6:0] ID_SHL   = 7'h5b;
    localparam logic [6:0] ID_SHLH  = 7'h5f;
    localparam logic [6:0] ID_SHLI  = 7'h3b;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [6:0] id_tab [8];

    fx2_issue_ctrl_if #(.REG_W(7)) bif ();
    fx2_issue_ctrl_if #(.REG_W(7)) bif2 ();

    fx2_issue_ctrl #(.LATENCY(L), .REG_W(7)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    fx2_issue_ctrl #(.LATENCY(L2), .REG_W(7)) dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive0(input logic v, input logic [6:0] id, input logic [6:0] ra,
                          input logic [6:0] rb, input logic [6:0] rt);
        bif.req0_valid = v; bif.req0_instr_id = id;
        bif.req0_ra = ra; bif.req0_rb = rb; bif.req0_rt = rt;
    endtask

    task automatic drive1(input logic v, input logic [6:0] id, input logic [6:0] ra,
                          input logic [6:0] rb, input logic [6:0] rt);
        bif.req1_valid = v; bif.req1_instr_id = id;
        bif.req1_ra = ra; bif.req1_rb = rb; bif.req1_rt = rt;
    endtask

    task automatic idle_all();
        drive0(1'b0, 7'd0, 7'd20, 7'd21, 7'd0);
        drive1(1'b0, 7'd0, 7'd20, 7'd21, 7'd0);
        bif.flush = 1'b0;
        bif2.req0_valid = 1'b0; bif2.req0_instr_id = 7'd0;
        bif2.req0_ra = 7'd20; bif2.req0_rb = 7'd21; bif2.req0_rt = 7'd0;
        bif2.req1_valid = 1'b0; bif2.req1_instr_id = 7'd0;
        bif2.req1_ra = 7'd20; bif2.req1_rb = 7'd21; bif2.req1_rt = 7'd0;
        bif2.flush = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // vector table
    typedef struct {
        logic       r0v;
        logic       r1v;
        logic       fl;
        logic       eg0;
        logic       eg1;
        logic       esel;
        logic [6:0] eid;
    } vec_t;
    vec_t vecs [10];

    // reference model: in-flight ops keyed by the cycle they write back
    typedef struct {
        int         due;
        logic [6:0] rt;
        logic [6:0] id;
    } op_t;
    op_t inflight [$];

    // scoreboard for the back-to-back writeback sequence
    logic [6:0] exp_q [$];

    initial begin
        n_checks = 0;
        n_errors = 0;
        id_tab[0] = ID_ROT;  id_tab[1] = ID_ROTH; id_tab[2] = 7'h38; id_tab[3] = 7'h3c;
        id_tab[4] = ID_SHL;  id_tab[5] = ID_SHLH; id_tab[6] = ID_SHLI; id_tab[7] = 7'h3f;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ID_ROT};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ID_SHL};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ID_ROT};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ID_SHL};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ID_SHL};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'd0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ID_ROT};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ID_SHL};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ID_ROT};

        // reset state
        do_reset();
        sample();
        check("rst_gnt0", bif.gnt0, 0);
        check("rst_gnt1", bif.gnt1, 0);
        check("rst_alu_id", bif.alu_instr_id, 0);
        check("rst_alu_sel", bif.alu_sel, 0);
        check("rst_wb_valid", bif.wb_valid, 0);
        check("rst_wb_rt", bif.wb_rt, 0);
        check("rst_wb_id", bif.wb_instr_id, 0);
        check("rst_busy", bif.busy, 0);
        check("rst_ptr", bif.dbg_ptr, 0);
        tick();

        // arbitration table from a fresh reset
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive0(vecs[i].r0v, ID_ROT, 7'd50, 7'd51, 7'd40);
            drive1(vecs[i].r1v, ID_SHL, 7'd52, 7'd53, 7'd41);
            bif.flush = vecs[i].fl;
            sample();
            check($sformatf("vec%0d_gnt0", i), bif.gnt0, vecs[i].eg0);
            check($sformatf("vec%0d_gnt1", i), bif.gnt1, vecs[i].eg1);
            check($sformatf("vec%0d_sel", i), bif.alu_sel, vecs[i].esel);
            check($sformatf("vec%0d_id", i), bif.alu_instr_id, vecs[i].eid);
            tick();
        end
        idle_all();
        repeat (L + 1) tick();

        // single issue, writeback after LATENCY cycles, busy in between
        do_reset();
        drive0(1'b1, ID_SHL, 7'd20, 7'd21, 7'd5);
        sample();
        check("single_gnt0", bif.gnt0, 1);
        check("single_alu_id", bif.alu_instr_id, ID_SHL);
        check("single_busy_t0", bif.busy, 0);
        tick();
        idle_all();
        for (int i = 1; i <= L; i++) begin
            sample();
            check($sformatf("single_busy_t%0d", i), bif.busy, 1);
            check($sformatf("single_wbv_t%0d", i), bif.wb_valid, (i == L));
            if (i == L) begin
                check("single_wb_rt", bif.wb_rt, 5);
                check("single_wb_id", bif.wb_instr_id, ID_SHL);
            end
            tick();
        end
        sample();
        check("single_busy_after", bif.busy, 0);
        tick();

        // both requesters held for four cycles: alternating grants, back-to-back writebacks
        do_reset();
        drive0(1'b1, ID_ROT, 7'd20, 7'd21, 7'd1);
        drive1(1'b1, ID_ROTH, 7'd22, 7'd23, 7'd2);
        for (int i = 0; i < 4; i++) begin
            sample();
            check($sformatf("rr_gnt0_%0d", i), bif.gnt0, (i % 2 == 0));
            check($sformatf("rr_gnt1_%0d", i), bif.gnt1, (i % 2 == 1));
            exp_q.push_back((i % 2 == 0) ? 7'd1 : 7'd2);
            tick();
        end
        idle_all();
        for (int i = 0; i < 4; i++) begin
            sample();
            check($sformatf("rr_wbv_%0d", i), bif.wb_valid, 1);
            if (exp_q.size() > 0) check($sformatf("rr_wbrt_%0d", i), bif.wb_rt, exp_q.pop_front());
            tick();
        end
        sample();
        check("rr_wbv_end", bif.wb_valid, 0);
        tick();

        // flush two cycles after a grant
        do_reset();
        drive0(1'b1, ID_SHLH, 7'd20, 7'd21, 7'd3);
        sample();
        check("fl_gnt0", bif.gnt0, 1);
        tick();
        idle_all();
        sample();
        tick();
        drive0(1'b1, ID_SHLH, 7'd20, 7'd21, 7'd4);
        bif.flush = 1'b1;
        sample();
        check("fl_gnt_suppressed", bif.gnt0, 0);
        check("fl_alu_id", bif.alu_instr_id, 0);
        tick();
        idle_all();
        sample();
        check("fl_busy_t3", bif.busy, 0);
        check("fl_wbv_t3", bif.wb_valid, 0);
        tick();
        sample();
        check("fl_wbv_t4", bif.wb_valid, 0);
        check("fl_busy_t4", bif.busy, 0);
        tick();

        // RAW: req1 reads the rt req0 just issued
        do_reset();
        drive0(1'b1, ID_SHL, 7'd20, 7'd21, 7'd9);
        sample();
        check("raw_gnt0", bif.gnt0, 1);
        tick();
        drive0(1'b0, 7'd0, 7'd20, 7'd21, 7'd0);
        drive1(1'b1, ID_SHLH, 7'd9, 7'd30, 7'd11);
`ifdef FX2_HAZARD_EN
        for (int i = 1; i < L; i++) begin
            sample();
            check($sformatf("raw_stall_%0d", i), bif.gnt1, 0);
            tick();
        end
        sample();
        check("raw_release_gnt1", bif.gnt1, 1);
        check("raw_release_wbv", bif.wb_valid, 1);
        check("raw_release_wbrt", bif.wb_rt, 9);
        tick();
`else
        sample();
        check("raw_nohaz_gnt1", bif.gnt1, 1);
        tick();
`endif
        idle_all();
        repeat (L + 1) tick();

        // reset pulse with three operations in flight
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive0(1'b1, ID_ROT, 7'd20, 7'd21, 7'(i));
            sample();
            check($sformatf("rp_gnt0_%0d", i), bif.gnt0, 1);
            tick();
        end
        rst_n = 1'b0;
        sample();
        check("rp_gnt_in_reset", bif.gnt0, 0);
        check("rp_alu_id_in_reset", bif.alu_instr_id, 0);
        tick();
        rst_n = 1'b1;
        idle_all();
        for (int i = 0; i < L + 2; i++) begin
            sample();
            check($sformatf("rp_wbv_%0d", i), bif.wb_valid, 0);
            tick();
        end
        check("rp_ptr", bif.dbg_ptr, 0);
        drive0(1'b1, ID_ROT, 7'd20, 7'd21, 7'd1);
        drive1(1'b1, ID_ROT, 7'd20, 7'd21, 7'd2);
        sample();
        check("rp_both_gnt0", bif.gnt0, 1);
        check("rp_both_gnt1", bif.gnt1, 0);
        tick();
        idle_all();
        repeat (L + 1) tick();

        // LATENCY=2 instance
        do_reset();
        bif2.req0_valid = 1'b1; bif2.req0_instr_id = ID_SHLI; bif2.req0_rt = 7'd6;
        sample();
        check("l2_gnt0", bif2.gnt0, 1);
        tick();
        bif2.req0_valid = 1'b0;
        sample();
        check("l2_wbv_t1", bif2.wb_valid, 0);
        tick();
        sample();
        check("l2_wbv_t2", bif2.wb_valid, 1);
        check("l2_wbrt_t2", bif2.wb_rt, 6);
        check("l2_wbid_t2", bif2.wb_instr_id, ID_SHLI);
        tick();
        sample();
        check("l2_wbv_t3", bif2.wb_valid, 0);
        tick();

        // randomized run against the due-time model
        begin
            int   cyc;
            logic m_ptr;
            logic m_sel;
            logic r, fl, v0, v1, h0, h1, e0, e1, g0, g1, e_wbv, e_busy;
            logic [6:0] ra0, rb0, rt0, id0, ra1, rb1, rt1, id1, e_wbrt, e_wbid, e_aid;

            do_reset();
            inflight.delete();
            m_ptr = 1'b0;
            m_sel = 1'b0;
            cyc   = 0;
            for (int n = 0; n < 600; n++) begin
                r   = ($urandom_range(0, 49) != 0);
                fl  = ($urandom_range(0, 19) == 0);
                v0  = ($urandom_range(0, 3) != 0);
                v1  = ($urandom_range(0, 3) != 0);
                ra0 = 7'($urandom_range(0, 7)); rb0 = 7'($urandom_range(0, 7));
                rt0 = 7'($urandom_range(0, 7)); id0 = id_tab[$urandom_range(0, 7)];
                ra1 = 7'($urandom_range(0, 7)); rb1 = 7'($urandom_range(0, 7));
                rt1 = 7'($urandom_range(0, 7)); id1 = id_tab[$urandom_range(0, 7)];
                rst_n = r;
                bif.flush = fl;
                drive0(v0, id0, ra0, rb0, rt0);
                drive1(v1, id1, ra1, rb1, rt1);

                for (int j = inflight.size() - 1; j >= 0; j--)
                    if (inflight[j].due < cyc) inflight.delete(j);
                e_busy = (inflight.size() > 0);
                e_wbv  = 1'b0;
                e_wbrt = 7'd0;
                e_wbid = 7'd0;
                h0 = 1'b0;
                h1 = 1'b0;
                foreach (inflight[j]) begin
                    if (inflight[j].due == cyc) begin
                        e_wbv  = 1'b1;
                        e_wbrt = inflight[j].rt;
                        e_wbid = inflight[j].id;
                    end
`ifdef FX2_HAZARD_EN
                    if (inflight[j].due > cyc) begin
                        if (ra0 == inflight[j].rt || rb0 == inflight[j].rt) h0 = 1'b1;
                        if (ra1 == inflight[j].rt || rb1 == inflight[j].rt) h1 = 1'b1;
                    end
`endif
                end
                e0 = v0 && !h0 && r && !fl;
                e1 = v1 && !h1 && r && !fl;
                g0 = e0 && (!e1 || !m_ptr);
                g1 = e1 && (!e0 || m_ptr);
                e_aid = g1 ? id1 : (g0 ? id0 : 7'd0);

                sample();
                check("rnd_gnt0", bif.gnt0, g0);
                check("rnd_gnt1", bif.gnt1, g1);
                check("rnd_alu_id", bif.alu_instr_id, e_aid);
                check("rnd_alu_sel", bif.alu_sel, (g0 || g1) ? g1 : m_sel);
                check("rnd_busy", bif.busy, e_busy);
                check("rnd_wb_valid", bif.wb_valid, e_wbv);
                if (e_wbv) begin
                    check("rnd_wb_rt", bif.wb_rt, e_wbrt);
                    check("rnd_wb_id", bif.wb_instr_id, e_wbid);
                end

                if (!r) begin
                    inflight.delete();
                    m_ptr = 1'b0;
                    m_sel = 1'b0;
                end else begin
                    if (fl) inflight.delete();
                    if (g0 || g1) begin
                        inflight.push_back('{cyc + L, g1 ? rt1 : rt0, e_aid});
                        m_ptr = g0;
                        m_sel = g1;
                    end
                end
                tick();
                cyc++;
            end
        end

        rst_n = 1'b1;
        idle_all();
        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fx2_issue_ctrl.md
FX2_ISSUE_CTRL -- requirements
Module: fx2_issue_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 4, FX2 result latency in cycles from grant to writeback; legal 2..7.
REQ-002 SHALL have parameter REG_W, default 7, register-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports reqN_valid  input  1  requester N (N=0,1) holds an FX2 instruction.
REQ-006 SHALL have ports reqN_instr_id  input  7  FX2 instruction ID (rot, roth, roti, rothi, shl, shlh, shli, shlhi).
REQ-007 SHALL have ports reqN_ra, reqN_rb, reqN_rt  input  REG_W each  source and destination addresses.
REQ-008 SHALL have ports gntN  output  1  requester N issued this cycle.
REQ-009 SHALL have port alu_sel  output  1  requester whose operands drive the ALU this cycle.
REQ-010 SHALL have port alu_instr_id  output  7  ID presented to the ALU; 0 when nothing is issued.
REQ-011 SHALL have port flush  input  1  kill all in-flight operations.
REQ-012 SHALL have ports wb_valid  output  1, wb_rt  output  REG_W, wb_instr_id  output  7  writeback qualifier and tag.
REQ-013 SHALL have port busy  output  1  any stage of the in-flight pipeline is valid.

Function
REQ-014 SHALL grant at most one requester per cycle; a grant is combinational in the cycle the request is eligible.
REQ-015 SHALL arbitrate round-robin: a 1-bit pointer names the preferred requester, and after a grant the pointer moves to the other requester.
REQ-016 SHALL issue the lone eligible requester regardless of the pointer, and SHALL leave the pointer unchanged when nothing is granted.
REQ-017 SHALL, on a grant, load {valid, rt, instr_id} into stage 1 of a LATENCY-deep valid/tag shift register that advances every cycle.
REQ-018 SHALL assert wb_valid with the granted rt and instr_id exactly LATENCY cycles after the grant cycle.
REQ-019 SHALL sustain one issue per cycle, giving back-to-back writebacks.
REQ-020 SHALL drive alu_instr_id as the granted ID; with no grant, alu_instr_id is 0 and alu_sel holds its last value.
REQ-021 SHALL, on flush, clear all stage valids on the next edge, deassert gnt0 and gnt1 in the flush cycle, and leave the pointer unchanged.
REQ-022 SHALL assert busy combinationally whenever any stage valid is 1.
REQ-023 SHALL keep requester-to-grant behaviour stateless apart from the pointer; a requester not granted holds its request, and dropping the request is legal.

Reset
REQ-024 SHALL, with rst_n low at a clock edge, clear all stage valids and tags, set the pointer to requester 0, and drive wb_valid, wb_rt and wb_instr_id to 0.
REQ-025 SHALL force gnt0, gnt1 and alu_instr_id to 0 while rst_n is low; rst_n low mid-operation discards in-flight work with no writeback.

Configuration
REQ-026 SHALL support macro FX2_HAZARD_EN.
  - Defined: a request is eligible only if its ra and rb match no valid in-flight stage rt, excluding the stage writing back this cycle (RAW interlock).
  - Undefined: every valid request is eligible and no address comparison logic exists.

Verification
REQ-027 SHALL verify: reset, then req0 valid with rt=5 and ID shl -> gnt0 in the same cycle; wb_valid with wb_rt=5 exactly 4 cycles later; busy high for those 4 cycles.
REQ-028 SHALL verify: both requesters held valid for 4 cycles after reset -> grants 0,1,0,1; writebacks occur on 4 consecutive cycles.
REQ-029 SHALL verify: grant at cycle t, flush at t+2 -> no wb_valid at t+4; busy low from t+3.
REQ-030 SHALL verify with FX2_HAZARD_EN: req0 rt=9 granted, next cycle req1 ra=9 -> gnt1 low for 3 cycles and high in the cycle wb_rt=9; without the macro -> gnt1 high immediately.
REQ-031 SHALL verify: rst_n low for one cycle with 3 operations in flight -> wb_valid never asserts; pointer back to 0.
REQ-032 SHALL verify: LATENCY=2, single issue -> wb_valid 2 cycles after the grant.
